dram_loader: RTL and testbench

//  Diagnostic write path into the IR dispatch RAM (DRAM). Assembles an even/odd DRAM word pair from

---
 rtl/dram_loader.sv | 189 ++++++++++++++++++
 tb/tb_dram_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_loader.sv
// dram_loader: diagnostic write path into the IR dispatch RAM.
// Stages an even/odd DRAM word pair from EBUS diagnostic load functions, writes
// the pair in two consecutive cycles on COMMIT, and reads it back and checks it
// on VERIFY. All outputs are registered.
module dram_loader #(
    parameter int DRAM_WIDTH = 15,
    parameter int PAIR_BITS  = 8,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  diag_load,
    input  logic [2:0]            diag_func,
    input  logic [7:0]            ebus_in,
    output logic [PAIR_BITS:0]    dram_addr,
    output logic [DRAM_WIDTH-1:0] dram_din,
    output logic                  dram_we,
    input  logic [DRAM_WIDTH-1:0] dram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic                  par_err,
    output logic                  overrun,
    output logic [5:0]            status
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_EVEN = 3'd1,
        WR_ODD  = 3'd2,
        RD_EVEN = 3'd3,
        RD_ODD  = 3'd4,
        RD_CHK  = 3'd5
    } state_t;

    // EBUS bit 0 is the MSB of ebus_in, so ebus[0:n] maps to ebus_in[7:7-n].
    localparam logic [2:0] F_EVEN_AB = 3'd0;
    localparam logic [2:0] F_ODD_AB  = 3'd1;
    localparam logic [2:0] F_JC      = 3'd2;
    localparam logic [2:0] F_EVEN_J  = 3'd3;
    localparam logic [2:0] F_ODD_J   = 3'd4;
    localparam logic [2:0] F_PAIR    = 3'd5;
    localparam logic [2:0] F_COMMIT  = 3'd6;
    localparam logic [2:0] F_VERIFY  = 3'd7;

    // Parity bit that makes the 15-bit word XOR to 1.
    function automatic logic odd_par_bit(input logic [13:0] d);
        return ~^d;
    endfunction

    // Assemble {A,B,P,Jc[1:4],Jc7,J[8:10]}.
    function automatic logic [DRAM_WIDTH-1:0] make_word(input logic [5:0] ab,
                                                        input logic [4:0] jc,
                                                        input logic [2:0] j);
        return {ab, odd_par_bit({ab, jc, j}), jc, j};
    endfunction

    state_t                 state_r, next_state_s;
    logic [5:0]             ab_even_r, ab_odd_r;
    logic [4:0]             jc_r;
    logic [2:0]             j_even_r, j_odd_r;
    logic [PAIR_BITS-1:0]   pair_r, pair_next_s;
    logic [DRAM_WIDTH-1:0]  even_word_s, odd_word_s;
    logic                   accept_s;
    logic                   even_mis_r, even_par_r;
    logic                   we_s;
    logic [PAIR_BITS:0]     addr_s;
    logic [DRAM_WIDTH-1:0]  din_s;

    assign accept_s    = diag_load && (state_r == IDLE);
    assign even_word_s = make_word(ab_even_r, jc_r, j_even_r);
    assign odd_word_s  = make_word(ab_odd_r,  jc_r, j_odd_r);
    assign status      = {busy, mismatch, par_err, overrun, pair_r[PAIR_BITS-1 -: 2]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Next-state logic: COMMIT/VERIFY only start from IDLE.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s && (diag_func == F_COMMIT))      next_state_s = WR_EVEN;
                else if (accept_s && (diag_func == F_VERIFY)) next_state_s = RD_EVEN;
                else                                          next_state_s = IDLE;
            end
            WR_EVEN: next_state_s = WR_ODD;
            WR_ODD:  next_state_s = IDLE;
            RD_EVEN: next_state_s = RD_ODD;
            RD_ODD:  next_state_s = RD_CHK;
            RD_CHK:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next pair address: explicit load, or post-commit increment.
    always_comb begin
        pair_next_s = pair_r;
        if (accept_s && (diag_func == F_PAIR))
            pair_next_s = ebus_in[PAIR_BITS-1:0];
        else if ((state_r == WR_ODD) && AUTO_INC)
            pair_next_s = pair_r + {{(PAIR_BITS-1){1'b0}}, 1'b1};
        else
            pair_next_s = pair_r;
    end

    // DRAM port values for the coming cycle, derived from the next state.
    always_comb begin
        we_s   = 1'b0;
        addr_s = {pair_next_s, 1'b0};
        din_s  = {DRAM_WIDTH{1'b0}};
        case (next_state_s)
            WR_EVEN: begin we_s = 1'b1; din_s = even_word_s; end
            WR_ODD:  begin we_s = 1'b1; din_s = odd_word_s; addr_s = {pair_next_s, 1'b1}; end
            RD_ODD:  addr_s = {pair_next_s, 1'b1};
            RD_CHK:  addr_s = {pair_next_s, 1'b1};
            default: addr_s = {pair_next_s, 1'b0};
        endcase
    end

    // Staging registers and pair address; frozen while a sequence runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_even_r <= 6'd0;
            ab_odd_r  <= 6'd0;
            jc_r      <= 5'd0;
            j_even_r  <= 3'd0;
            j_odd_r   <= 3'd0;
            pair_r    <= {PAIR_BITS{1'b0}};
        end else begin
            pair_r <= pair_next_s;
            if (accept_s) begin
                case (diag_func)
                    F_EVEN_AB: ab_even_r <= ebus_in[7:2];
                    F_ODD_AB:  ab_odd_r  <= ebus_in[7:2];
                    F_JC:      jc_r      <= ebus_in[7:3];
                    F_EVEN_J:  j_even_r  <= ebus_in[7:5];
                    F_ODD_J:   j_odd_r   <= ebus_in[7:5];
                    default:   ab_even_r <= ab_even_r;
                endcase
            end
        end
    end

    // Registered DRAM port, busy and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            dram_we   <= 1'b0;
            dram_addr <= {(PAIR_BITS+1){1'b0}};
            dram_din  <= {DRAM_WIDTH{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            dram_we   <= we_s;
            dram_addr <= addr_s;
            dram_din  <= din_s;
            busy      <= (next_state_s != IDLE);
            done      <= (state_r == WR_ODD) || (state_r == RD_CHK);
        end
    end

    // Readback checking and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            even_mis_r <= 1'b0;
            even_par_r <= 1'b0;
            mismatch   <= 1'b0;
            par_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (diag_load && (state_r != IDLE)) overrun <= 1'b1;
            if (state_r == RD_ODD) begin
                even_mis_r <= (dram_dout != even_word_s);
                even_par_r <= ~^dram_dout;
            end
            if (accept_s && (diag_func == F_COMMIT)) begin
                mismatch <= 1'b0;
                par_err  <= 1'b0;
            end else if (state_r == RD_CHK) begin
                mismatch <= mismatch | even_mis_r | (dram_dout != odd_word_s);
                par_err  <= par_err | even_par_r | (~^dram_dout);
            end
        end
    end

endmodule

// File: tb/tb_dram_loader.sv
// Randomized self-checking bench for dram_loader with a behavioural model and model RAM.
module tb_dram_loader;

    logic        clk = 1'b0;
    logic        reset, diag_load;
    logic [2:0]  diag_func;
    logic [7:0]  ebus_in;
    logic [8:0]  dram_addr;
    logic [14:0] dram_din, dram_dout;
    logic        dram_we, busy, done, mismatch, par_err, overrun;
    logic [5:0]  status;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [5:0]  m_ab [2];
    logic [4:0]  m_jc;
    logic [2:0]  m_j [2];
    logic [7:0]  m_pair;
    logic        m_mis, m_par, m_ovr;
    logic [14:0] ram [512];
    logic [14:0] ref_mem [512];
    logic        corr_en;
    logic [8:0]  corr_addr;
    logic [14:0] corr_mask;

    always #5 clk = ~clk;

    dram_loader dut (
        .clk(clk), .reset(reset), .diag_load(diag_load), .diag_func(diag_func),
        .ebus_in(ebus_in), .dram_addr(dram_addr), .dram_din(dram_din), .dram_we(dram_we),
        .dram_dout(dram_dout), .busy(busy), .done(done), .mismatch(mismatch),
        .par_err(par_err), .overrun(overrun), .status(status)
    );

    // Model RAM with registered read and optional read corruption.
    always @(posedge clk) begin
        if (dram_we) ram[dram_addr] <= dram_din;
        dram_dout <= ram[dram_addr] ^ ((corr_en && dram_addr == corr_addr) ? corr_mask : 15'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [14:0] mk_word(input logic [5:0] ab, input logic [4:0] jc, input logic [2:0] j);
        logic p;
        p = ($countones({ab, jc, j}) % 2 == 0);
        return {ab, p, jc, j};
    endfunction

    function automatic logic [14:0] corr(input logic [8:0] a);
        return (corr_en && a == corr_addr) ? corr_mask : 15'h0000;
    endfunction

    function automatic logic [5:0] exp_status(input logic b);
        return {b, m_mis, m_par, m_ovr, m_pair[7:6]};
    endfunction

    task automatic model_reset();
        m_ab[0] = 6'd0; m_ab[1] = 6'd0; m_jc = 5'd0; m_j[0] = 3'd0; m_j[1] = 3'd0;
        m_pair = 8'd0; m_mis = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, dram_we, 32'd0);
        check({tag, "_addr"}, dram_addr, 32'd0);
        check({tag, "_din"}, dram_din, 32'd0);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_flags"}, {mismatch, par_err, overrun}, 32'd0);
        check({tag, "_status"}, status, 32'd0);
    endtask

    // Issue a staging function from the current negedge (FSM must be idle).
    task automatic do_load(input logic [2:0] f, input logic [7:0] e);
        diag_load = 1'b1; diag_func = f; ebus_in = e;
        @(negedge clk);
        diag_load = 1'b0;
        case (f)
            3'd0: m_ab[0] = e[7:2];
            3'd1: m_ab[1] = e[7:2];
            3'd2: m_jc    = e[7:3];
            3'd3: m_j[0]  = e[7:5];
            3'd4: m_j[1]  = e[7:5];
            3'd5: m_pair  = e;
            default: ;
        endcase
    endtask

    // COMMIT issued at the current negedge (cycle T); returns at the negedge of T+3.
    task automatic do_commit(input bit inject);
        logic [7:0]  p;
        logic [14:0] w0, w1;
        p = m_pair; w0 = mk_word(m_ab[0], m_jc, m_j[0]); w1 = mk_word(m_ab[1], m_jc, m_j[1]);
        diag_load = 1'b1; diag_func = 3'd6; ebus_in = 8'($urandom);
        @(negedge clk);
        diag_load = 1'b0;
        m_mis = 1'b0; m_par = 1'b0;
        check("c1_we", dram_we, 32'd1);
        check("c1_addr", dram_addr, {p, 1'b0});
        check("c1_din", dram_din, w0);
        check("c1_busy", busy, 32'd1);
        check("c1_done", done, 32'd0);
        if (inject) begin
            diag_load = 1'b1; diag_func = 3'd0; ebus_in = ~{m_ab[0], 2'b00};
            m_ovr = 1'b1;
        end
        @(negedge clk);
        diag_load = 1'b0;
        check("c2_we", dram_we, 32'd1);
        check("c2_addr", dram_addr, {p, 1'b1});
        check("c2_din", dram_din, w1);
        check("c2_busy", busy, 32'd1);
        ref_mem[{p, 1'b0}] = w0; ref_mem[{p, 1'b1}] = w1;
        m_pair = p + 8'd1;
        @(negedge clk);
        check("c3_done", done, 32'd1);
        check("c3_we", dram_we, 32'd0);
        check("c3_busy", busy, 32'd0);
        check("c3_addr", dram_addr, {m_pair, 1'b0});
        check("c3_status", status, exp_status(1'b0));
    endtask

    // VERIFY issued at the current negedge (cycle T); returns at the negedge of T+4.
    task automatic do_verify();
        logic [7:0]  p;
        logic [14:0] w0, w1, r0, r1;
        p = m_pair; w0 = mk_word(m_ab[0], m_jc, m_j[0]); w1 = mk_word(m_ab[1], m_jc, m_j[1]);
        r0 = ref_mem[{p, 1'b0}] ^ corr({p, 1'b0});
        r1 = ref_mem[{p, 1'b1}] ^ corr({p, 1'b1});
        diag_load = 1'b1; diag_func = 3'd7; ebus_in = 8'($urandom);
        @(negedge clk);
        diag_load = 1'b0;
        check("v1_addr", dram_addr, {p, 1'b0});
        check("v1_we", dram_we, 32'd0);
        check("v1_busy", busy, 32'd1);
        @(negedge clk);
        check("v2_addr", dram_addr, {p, 1'b1});
        check("v2_we", dram_we, 32'd0);
        @(negedge clk);
        check("v3_busy", busy, 32'd1);
        check("v3_done", done, 32'd0);
        m_mis = m_mis | (r0 != w0) | (r1 != w1);
        m_par = m_par | ($countones(r0) % 2 == 0) | ($countones(r1) % 2 == 0);
        @(negedge clk);
        check("v4_done", done, 32'd1);
        check("v4_busy", busy, 32'd0);
        check("v4_mismatch", mismatch, m_mis);
        check("v4_par_err", par_err, m_par);
        check("v4_addr", dram_addr, {p, 1'b0});
        check("v4_status", status, exp_status(1'b0));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin ram[i] = 15'h0000; ref_mem[i] = 15'h0000; end
        corr_en = 1'b0; corr_addr = 9'd0; corr_mask = 15'd0;
        reset = 1'b1; diag_load = 1'b0; diag_func = 3'd0; ebus_in = 8'd0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check_zero("rst");

        // 1: directed pair write
        do_load(3'd0, {6'o52, 2'b00});
        do_load(3'd2, {5'b10110, 3'b000});
        do_load(3'd3, {3'b101, 5'b00000});
        do_load(3'd5, 8'h3C);
        do_commit(1'b0);
        check("t1_ram_even", ram[9'h078], 32'h55B5);
        check("t1_ram_odd", ram[9'h079], 32'h00B0);
        check("t1_par_even", $countones(ram[9'h078]) % 2, 32'd1);
        check("t1_par_odd", $countones(ram[9'h079]) % 2, 32'd1);
        check("t1_pair", dram_addr, 32'h07A);

        // 2: wrap of pair address
        do_load(3'd5, 8'hFF);
        do_commit(1'b0);
        check("t2_wrap", dram_addr, 32'h000);

        // 3: verify clean, then with bit 3 of the odd word corrupted
        do_load(3'd5, 8'hFF);
        do_verify();
        check("t3_clean", {mismatch, par_err}, 32'd0);
        corr_en = 1'b1; corr_addr = 9'h1FF; corr_mask = 15'h0008;
        do_verify();
        check("t3_corrupt", {mismatch, par_err}, 32'd3);
        corr_en = 1'b0;

        // 4: overrun during commit, staged even word unaffected
        do_load(3'd0, 8'hA4);
        do_commit(1'b1);
        check("t4_overrun", overrun, 32'd1);
        do_commit(1'b0);

        // 5: reset while in WR_EVEN
        diag_load = 1'b1; diag_func = 3'd6;
        @(negedge clk);
        diag_load = 1'b0;
        check("t5_we", dram_we, 32'd1);
        ref_mem[{m_pair, 1'b0}] = mk_word(m_ab[0], m_jc, m_j[0]);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_zero("t5a");
        @(negedge clk);
        check_zero("t5b");

        // 6: back-to-back commit then verify of the incremented pair
        do_load(3'd1, 8'h5C);
        do_load(3'd4, 8'hE0);
        do_commit(1'b0);
        do_verify();

        // Randomized sequences
        for (int it = 0; it < 40; it++) begin
            int nl;
            logic [7:0] cp;
            nl = $urandom_range(1, 5);
            for (int k = 0; k < nl; k++) do_load(3'($urandom_range(0, 5)), 8'($urandom));
            cp = m_pair;
            do_commit(1'b0);
            if ($urandom_range(0, 3) != 0) do_load(3'd5, cp);
            if ($urandom_range(0, 2) == 0) begin
                corr_en = 1'b1;
                corr_addr = {m_pair, 1'($urandom)};
                corr_mask = 15'(1 << $urandom_range(0, 14));
            end
            do_verify();
            corr_en = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
